rx_clk_supervisor: RTL and testbench

Supervises the receive-side clock manager (DCM) of the 10G MAC. It pulses the DCM reset and waits for lock with a timeout and bounded retries. Once lock is stable, it releases a parametrised number of downstream reset domains in staggered order. It also drops them all again and restarts if lock is lost. It runs on the free-running input receive clock and replaces ad-hoc use of the raw DCM `locked` output.

---
 rtl/rx_clk_supervisor.sv | 157 +++++++++++++++
 tb/tb_rx_clk_supervisor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_clk_supervisor.sv
// Receive-clock DCM supervisor: pulses the DCM reset, waits for a stable lock with
// timeout/retry, then releases downstream reset domains one after another.
module rx_clk_supervisor #(
    parameter int NUM_DOMAINS  = 2,
    parameter int RST_PULSE    = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int SETTLE       = 16,
    parameter int STAGGER      = 4,
    parameter int MAX_RETRY    = 7,
    parameter int CNT_W        = 16
) (
    input  logic                   rxclk,
    input  logic                   reset,
    input  logic                   dcm_locked,
    output logic                   dcm_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   locked,
    output logic                   fail,
    output logic [3:0]             retry_cnt,
    output logic [7:0]             loss_cnt
);

    typedef enum logic [2:0] {
        ST_RST_DCM,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_DOMAINS - 1) * STAGGER);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic [1:0]             sync_q;
    logic                   lk;
    logic                   dcm_rst_next;
    logic [NUM_DOMAINS-1:0] domain_rst_next;
    logic                   locked_next;
    logic                   fail_next;
    logic [3:0]             retry_next;
    logic [3:0]             retry_inc;
    logic [7:0]             loss_next;

    // dcm_locked is asynchronous to rxclk; two flops before anything looks at it.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], dcm_locked};
        end
    end

    assign lk        = sync_q[1];
    assign retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        loss_next  = loss_cnt;

        unique case (state)
            ST_RST_DCM: begin
                if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle wins over the retry.
                if (lk) begin
                    state_next = ST_SETTLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_next = retry_inc;
                    state_next = (32'(retry_inc) >= MAX_RETRY) ? ST_FAIL : ST_RST_DCM;
                end
            end
            ST_SETTLE: begin
                if (!lk) begin
                    state_next = ST_RST_DCM;
                end else if (cnt == SETTLE_LAST) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!lk) begin
                    state_next = ST_RST_DCM;
                    loss_next  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                end else if (cnt == RELEASE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_next = ST_RST_DCM;
                    loss_next  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_RST_DCM;
            end
        endcase

        // Counter restarts on every state change and saturates instead of wrapping.
        if (state_next != state) begin
            cnt_next = '0;
        end else if (cnt == {CNT_W{1'b1}}) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        dcm_rst_next    = (state_next == ST_RST_DCM) || (state_next == ST_FAIL);
        locked_next     = (state_next == ST_RUN);
        fail_next       = (state_next == ST_FAIL);
        domain_rst_next = '1;
        if (state_next == ST_RUN) begin
            domain_rst_next = '0;
        end else if (state_next == ST_RELEASE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                domain_rst_next[i] = (32'(cnt_next) < 32'(i * STAGGER));
            end
        end
    end

    always_ff @(posedge rxclk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RST_DCM;
            cnt        <= '0;
            dcm_rst    <= 1'b1;
            domain_rst <= '1;
            locked     <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= 4'd0;
            loss_cnt   <= 8'd0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            dcm_rst    <= dcm_rst_next;
            domain_rst <= domain_rst_next;
            locked     <= locked_next;
            fail       <= fail_next;
            retry_cnt  <= retry_next;
            loss_cnt   <= loss_next;
        end
    end

endmodule

// File: tb/tb_rx_clk_supervisor.sv
// Scoreboard bench for rx_clk_supervisor: expected output snapshots are queued per
// cycle from the timing rules and compared when the run reaches that cycle.
module tb_rx_clk_supervisor;

    localparam int RST_PULSE = 8;
    localparam int SETTLE    = 16;
    localparam int LOCK_TO   = 16;
    localparam int MAX_RETRY = 7;
    localparam int ND_A      = 2;
    localparam int STAG_A    = 4;
    localparam int ND_B      = 4;
    localparam int STAG_B    = 1;
    // Cycle (after reset release or a restart) on which domain_rst[0] clears with lock present.
    localparam int T_REL     = RST_PULSE + 1 + SETTLE;

    logic rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    logic        reset;
    logic        dcm_locked;
    logic        dcm_rst_a, locked_a, fail_a;
    logic [1:0]  dom_a;
    logic [3:0]  retry_a;
    logic [7:0]  loss_a;
    logic        dcm_rst_b, locked_b, fail_b;
    logic [3:0]  dom_b;
    logic [3:0]  retry_b;
    logic [7:0]  loss_b;

    rx_clk_supervisor #(
        .NUM_DOMAINS(ND_A), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TO),
        .SETTLE(SETTLE), .STAGGER(STAG_A), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
    ) dut_a (
        .rxclk(rxclk), .reset(reset), .dcm_locked(dcm_locked),
        .dcm_rst(dcm_rst_a), .domain_rst(dom_a), .locked(locked_a),
        .fail(fail_a), .retry_cnt(retry_a), .loss_cnt(loss_a)
    );

    rx_clk_supervisor #(
        .NUM_DOMAINS(ND_B), .RST_PULSE(RST_PULSE), .LOCK_TIMEOUT(LOCK_TO),
        .SETTLE(SETTLE), .STAGGER(STAG_B), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
    ) dut_b (
        .rxclk(rxclk), .reset(reset), .dcm_locked(dcm_locked),
        .dcm_rst(dcm_rst_b), .domain_rst(dom_b), .locked(locked_b),
        .fail(fail_b), .retry_cnt(retry_b), .loss_cnt(loss_b)
    );

    typedef struct {
        int          cyc;
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];
    int   k;
    int   n_cmp;
    int   n_fail;
    bit   sel_b;

    // Snapshot layout: {dcm_rst, domain_rst[3:0], locked, fail, retry_cnt, loss_cnt}.
    function automatic logic [18:0] pack(input logic d, input logic [3:0] dom, input logic l,
                                         input logic f, input logic [3:0] r, input logic [7:0] lc);
        return {d, dom, l, f, r, lc};
    endfunction

    function automatic logic [3:0] dom_exp(input int n, input int cleared);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) d[i] = (i < n) && (i >= cleared);
        return d;
    endfunction

    function automatic logic [18:0] observe();
        if (sel_b) return pack(dcm_rst_b, dom_b, locked_b, fail_b, retry_b, loss_b);
        return pack(dcm_rst_a, {2'b00, dom_a}, locked_a, fail_a, retry_a, loss_a);
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void expect_at(input int cyc, input string tag, input logic [18:0] v);
        int i = 0;
        exp_t e;
        e.cyc = cyc;
        e.tag = tag;
        e.val = v;
        while (i < sb.size() && sb[i].cyc <= cyc) i++;
        sb.insert(i, e);
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= k) begin
            e = sb.pop_front();
            check($sformatf("%s@%0d", e.tag, e.cyc), observe(), e.val);
        end
    endtask

    task automatic step();
        @(posedge rxclk);
        k++;
        @(negedge rxclk);
        drain();
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic finish_run();
        while (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: cycle %0d never reached", sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
        end
    endtask

    task automatic start_run(input logic lock_level);
        @(negedge rxclk);
        reset      = 1'b0;
        dcm_locked = lock_level;
        repeat (2) @(negedge rxclk);
        reset = 1'b1;
        k     = 0;
        drain();
    endtask

    // Asserted between clock edges so only an asynchronous reset can satisfy it.
    task automatic async_reset_check(input string tag);
        int nd;
        nd    = sel_b ? ND_B : ND_A;
        reset = 1'b0;
        #1;
        check(tag, observe(), pack(1'b1, dom_exp(nd, 0), 1'b0, 1'b0, 4'd0, 8'd0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] all_a;
        int d1, r1, d2, r2, fail_k, to_k;
        reset      = 1'b0;
        dcm_locked = 1'b0;
        n_cmp      = 0;
        n_fail     = 0;
        k          = 0;
        sel_b      = 1'b0;
        all_a      = dom_exp(ND_A, 0);

        // Best-case bring-up, a short lock drop with full re-release, then async reset mid-RELEASE.
        d1 = T_REL + STAG_A + 11;
        r1 = d1 + 3;
        d2 = r1 + T_REL + STAG_A + 6;
        r2 = d2 + 3;
        expect_at(0, "rst_state", pack(1, all_a, 0, 0, 0, 0));
        expect_at(RST_PULSE - 1, "pulse_end", pack(1, all_a, 0, 0, 0, 0));
        expect_at(RST_PULSE, "wait_lock", pack(0, all_a, 0, 0, 0, 0));
        expect_at(T_REL - 1, "settle_end", pack(0, all_a, 0, 0, 0, 0));
        expect_at(T_REL, "rel_bit0", pack(0, dom_exp(ND_A, 1), 0, 0, 0, 0));
        expect_at(T_REL + STAG_A - 1, "rel_hold", pack(0, dom_exp(ND_A, 1), 0, 0, 0, 0));
        expect_at(T_REL + STAG_A, "rel_bit1", pack(0, dom_exp(ND_A, 2), 0, 0, 0, 0));
        expect_at(T_REL + STAG_A + 1, "run", pack(0, 4'b0, 1, 0, 0, 0));
        expect_at(d1 + 2, "pre_loss", pack(0, 4'b0, 1, 0, 0, 0));
        expect_at(r1, "loss", pack(1, all_a, 0, 0, 0, 1));
        expect_at(r1 + RST_PULSE - 1, "repulse_end", pack(1, all_a, 0, 0, 0, 1));
        expect_at(r1 + RST_PULSE, "rewait", pack(0, all_a, 0, 0, 0, 1));
        expect_at(r1 + T_REL - 1, "resettle_end", pack(0, all_a, 0, 0, 0, 1));
        expect_at(r1 + T_REL, "rerel_bit0", pack(0, dom_exp(ND_A, 1), 0, 0, 0, 1));
        expect_at(r1 + T_REL + STAG_A, "rerel_bit1", pack(0, dom_exp(ND_A, 2), 0, 0, 0, 1));
        expect_at(r1 + T_REL + STAG_A + 1, "rerun", pack(0, 4'b0, 1, 0, 0, 1));
        expect_at(r2, "loss2", pack(1, all_a, 0, 0, 0, 2));
        expect_at(r2 + T_REL, "rel2_bit0", pack(0, dom_exp(ND_A, 1), 0, 0, 0, 2));
        start_run(1'b1);
        run_to(d1);
        dcm_locked = 1'b0;
        run_to(d1 + 2);
        dcm_locked = 1'b1;
        run_to(d2);
        dcm_locked = 1'b0;
        run_to(d2 + 2);
        dcm_locked = 1'b1;
        run_to(r2 + T_REL + 1);
        finish_run();
        async_reset_check("reset_mid_release");

        // No lock ever: RST_PULSE + LOCK_TO cycles per attempt until FAIL.
        for (int p = 0; p < MAX_RETRY; p++) begin
            expect_at(p * (RST_PULSE + LOCK_TO), $sformatf("pulse%0d", p),
                      pack(1, all_a, 0, 0, 4'(p), 0));
            expect_at(p * (RST_PULSE + LOCK_TO) + RST_PULSE - 1, $sformatf("pulse%0d_end", p),
                      pack(1, all_a, 0, 0, 4'(p), 0));
            expect_at(p * (RST_PULSE + LOCK_TO) + RST_PULSE, $sformatf("wait%0d", p),
                      pack(0, all_a, 0, 0, 4'(p), 0));
        end
        fail_k = MAX_RETRY * (RST_PULSE + LOCK_TO);
        expect_at(fail_k - 1, "pre_fail", pack(0, all_a, 0, 0, 4'(MAX_RETRY - 1), 0));
        expect_at(fail_k, "fail", pack(1, all_a, 0, 1, 4'(MAX_RETRY), 0));
        expect_at(fail_k + 40, "fail_hold", pack(1, all_a, 0, 1, 4'(MAX_RETRY), 0));
        start_run(1'b0);
        run_to(fail_k + 40);
        finish_run();
        async_reset_check("fail_cleared");

        // Lock held for only 10 cycles inside SETTLE: nothing releases, loss_cnt untouched.
        expect_at(12, "waiting", pack(0, all_a, 0, 0, 0, 0));
        expect_at(13, "settle_in", pack(0, all_a, 0, 0, 0, 0));
        expect_at(22, "settle_last", pack(0, all_a, 0, 0, 0, 0));
        expect_at(23, "settle_abort", pack(1, all_a, 0, 0, 0, 0));
        expect_at(23 + RST_PULSE - 1, "abort_pulse_end", pack(1, all_a, 0, 0, 0, 0));
        expect_at(23 + RST_PULSE, "abort_wait", pack(0, all_a, 0, 0, 0, 0));
        expect_at(23 + RST_PULSE + LOCK_TO, "abort_timeout", pack(1, all_a, 0, 0, 1, 0));
        start_run(1'b0);
        run_to(10);
        dcm_locked = 1'b1;
        run_to(20);
        dcm_locked = 1'b0;
        run_to(23 + RST_PULSE + LOCK_TO);
        finish_run();

        // lk first seen high on the timeout cycle: lock wins, retry_cnt stays 0.
        to_k = RST_PULSE + LOCK_TO;
        expect_at(to_k - 1, "to_wait", pack(0, all_a, 0, 0, 0, 0));
        expect_at(to_k, "to_lock_wins", pack(0, all_a, 0, 0, 0, 0));
        expect_at(to_k + SETTLE, "to_release", pack(0, dom_exp(ND_A, 1), 0, 0, 0, 0));
        start_run(1'b0);
        run_to(to_k - 3);
        dcm_locked = 1'b1;
        run_to(to_k + SETTLE);
        finish_run();

        // Four domains, stagger of one: bits clear on consecutive cycles, LSB first.
        sel_b = 1'b1;
        expect_at(0, "b_rst", pack(1, dom_exp(ND_B, 0), 0, 0, 0, 0));
        expect_at(T_REL - 1, "b_settle_end", pack(1'b0, dom_exp(ND_B, 0), 0, 0, 0, 0));
        for (int j = 0; j < ND_B; j++) begin
            expect_at(T_REL + j * STAG_B, $sformatf("b_rel%0d", j),
                      pack(0, dom_exp(ND_B, j + 1), 0, 0, 0, 0));
        end
        expect_at(T_REL + (ND_B - 1) * STAG_B + 1, "b_run", pack(0, 4'b0, 1, 0, 0, 0));
        start_run(1'b1);
        run_to(T_REL + (ND_B - 1) * STAG_B + 3);
        finish_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
